// File: rtl/vm2002_stock_arbiter.sv
// vm2002_stock_arbiter: per-item stock count and price table shared by the
// vend path and the restock path. A round-robin arbiter picks one requester
// and a four-state sequencer (IDLE, READ, WRITE, DONE) performs the table
// update atomically, so the two paths can never interleave on an entry.
// Optional feature macro: VM2002_LOW_STOCK_EN adds the low_stock flags.
module vm2002_stock_arbiter #(
    parameter int NUM_ITEMS  = 8,
    parameter int CNT_W      = 4,
    parameter int MAX_COUNT  = 15,
    parameter int LOW_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 hrst_n,
    input  logic                 vend_req,
    input  logic [2:0]           vend_item,
    input  logic                 vend_dec,
    output logic                 vend_ack,
    output logic                 vend_avail,
    output logic [7:0]           vend_cost,
    output logic [1:0]           vend_status,
    input  logic                 rs_req,
    input  logic [2:0]           rs_item,
    input  logic [CNT_W-1:0]     rs_count,
    input  logic [7:0]           rs_cost,
    output logic                 rs_ack,
    output logic                 rs_err
`ifdef VM2002_LOW_STOCK_EN
    ,
    output logic [NUM_ITEMS-1:0] low_stock
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_EMPTY = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b10;

    state_t             state, state_nxt;
    logic               last_rs;   // 1 = restock was served last
    logic               srv_rs;    // 1 = current transaction is a restock
    logic               grant_rs;
    logic [2:0]         item_sel;
    logic               item_ok;
    logic [2:0]         item_q;
    logic               ok_q;
    logic               dec_q;
    logic [CNT_W-1:0]   add_q;
    logic [7:0]         pcost_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         cost_q;
    logic [CNT_W:0]     sum;
    logic [CNT_W-1:0]   count [NUM_ITEMS];
    logic [7:0]         cost  [NUM_ITEMS];

    // On a tie the requester that was not served last wins.
    assign grant_rs = rs_req & (~vend_req | ~last_rs);
    assign item_sel = grant_rs ? rs_item : vend_item;
    assign item_ok  = ({1'b0, item_sel} < 4'(NUM_ITEMS));
    // One extra bit so an add past MAX_COUNT is detected instead of wrapping.
    assign sum      = {1'b0, cnt_q} + {1'b0, add_q};

    // Sequencer state register.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and the single-cycle ack pulses in DONE.
    always_comb begin
        state_nxt = state;
        vend_ack  = 1'b0;
        rs_ack    = 1'b0;
        case (state)
            IDLE:  if (vend_req || rs_req) state_nxt = READ;
            READ:  state_nxt = WRITE;
            WRITE: state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                if (srv_rs) rs_ack   = 1'b1;
                else        vend_ack = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch winner and operands in IDLE; snapshot the table entry in READ.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            srv_rs  <= 1'b0;
            item_q  <= '0;
            ok_q    <= 1'b0;
            dec_q   <= 1'b0;
            add_q   <= '0;
            pcost_q <= '0;
            cnt_q   <= '0;
            cost_q  <= '0;
        end else begin
            case (state)
                IDLE: if (vend_req || rs_req) begin
                    srv_rs  <= grant_rs;
                    item_q  <= item_sel;
                    ok_q    <= item_ok;
                    dec_q   <= vend_dec;
                    add_q   <= rs_count;
                    pcost_q <= rs_cost;
                end
                READ: begin
                    // Out-of-range items are never read.
                    cnt_q  <= ok_q ? count[item_q] : '0;
                    cost_q <= ok_q ? cost[item_q]  : '0;
                end
                default: ;
            endcase
        end
    end

    // Table write-back, result registers and round-robin history in WRITE.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                count[i] <= '0;
                cost[i]  <= '0;
            end
            vend_avail  <= 1'b0;
            vend_cost   <= '0;
            vend_status <= ST_OK;
            rs_err      <= 1'b0;
            last_rs     <= 1'b1;
        end else if (state == WRITE) begin
            last_rs <= srv_rs;
            if (srv_rs) begin
                if (!ok_q || (sum > (CNT_W+1)'(MAX_COUNT))) begin
                    rs_err <= 1'b1;
                end else begin
                    rs_err        <= 1'b0;
                    count[item_q] <= sum[CNT_W-1:0];
                    if (pcost_q != 8'd0) cost[item_q] <= pcost_q;
                end
            end else if (!ok_q) begin
                vend_avail  <= 1'b0;
                vend_cost   <= '0;
                vend_status <= ST_ERROR;
            end else begin
                vend_avail  <= (cnt_q != '0);
                vend_cost   <= cost_q;
                vend_status <= (cnt_q != '0) ? ST_OK : ST_EMPTY;
                if (dec_q && (cnt_q != '0)) count[item_q] <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef VM2002_LOW_STOCK_EN
    // Low-stock flags follow the table one cycle behind any count write.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            low_stock <= '0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++)
                low_stock[i] <= (count[i] <= CNT_W'(LOW_THRESH));
        end
    end
`endif

endmodule
